// File: rtl/rx_pkg.sv
// Shared types for the RX-chain stimulus player: beat container and playback FSM states.
package rx_pkg;

    localparam int unsigned DefDataWidth = 16;
    localparam int unsigned DefPhases    = 16;

    // Beat container at the default lane configuration, for consumers such as rxTop.
    typedef struct packed {
        logic [DefPhases*DefDataWidth-1:0] re;
        logic [DefPhases*DefDataWidth-1:0] im;
    } iq_beat_t;

    typedef enum logic [1:0] {
        StIdle,
        StPlay,
        StGap
    } play_state_e;

    // What the output register loads on the next edge.
    typedef enum logic [1:0] {
        LdHold,
        LdRow,
        LdZero,
        LdClear
    } beat_load_e;

endpackage

// File: rtl/iq_bank_mem.sv
// One lane bank of the sample memory: synchronous write, asynchronous row read.
module iq_bank_mem #(
    parameter int unsigned DATAWIDTH = 16,
    parameter int unsigned ROWS      = 1024,
    parameter int unsigned ROW_W     = 10
) (
    input  logic                 clk_i,
    input  logic                 wr_en_i,
    input  logic [ROW_W-1:0]     wr_row_i,
    input  logic [DATAWIDTH-1:0] wr_re_i,
    input  logic [DATAWIDTH-1:0] wr_im_i,
    input  logic [ROW_W-1:0]     rd_row_i,
    output logic [DATAWIDTH-1:0] rd_re_o,
    output logic [DATAWIDTH-1:0] rd_im_o
);

    logic [2*DATAWIDTH-1:0] mem_q [ROWS];

    // Contents are deliberately not reset; a frame survives a reset of the player.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_row_i] <= {wr_re_i, wr_im_i};
        end
    end

    assign {rd_re_o, rd_im_o} = mem_q[rd_row_i];

endmodule

// File: rtl/iq_beat_player.sv
// Multi-phase IQ frame player: preloaded samples out as PHASES lanes per beat with
// zero padding, optional loop with zero-beat gap, and a valid/ready output handshake.
module iq_beat_player
    import rx_pkg::*;
#(
    parameter  int unsigned DATAWIDTH = 16,
    parameter  int unsigned PHASES    = 16,
    parameter  int unsigned DEPTH     = 16384,
    parameter  int unsigned GAP_W     = 8,
    localparam int unsigned ADDR_W    = $clog2(DEPTH),
    localparam int unsigned LEN_W     = $clog2(DEPTH + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        wr_en_i,
    input  logic [ADDR_W-1:0]           wr_addr_i,
    input  logic [DATAWIDTH-1:0]        wr_re_i,
    input  logic [DATAWIDTH-1:0]        wr_im_i,
    input  logic [LEN_W-1:0]            len_i,
    input  logic [GAP_W-1:0]            gap_i,
    input  logic                        loop_i,
    input  logic                        start_i,
    input  logic                        stop_i,
    output logic [DATAWIDTH*PHASES-1:0] re_o,
    output logic [DATAWIDTH*PHASES-1:0] im_o,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic                        last_o,
    output logic                        busy_o,
    output logic                        done_o
);

    localparam int unsigned ROWS    = DEPTH / PHASES;
    localparam int unsigned ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned LANE_SH = $clog2(PHASES);
    localparam int unsigned BEAT_W  = DATAWIDTH * PHASES;

    play_state_e state_q, state_d;
    beat_load_e  load_sel;

    logic [ROW_W-1:0]  row_q, row_d;
    logic [ROW_W-1:0]  last_row_q, last_row_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              loop_q, loop_d;
    logic              stop_q, stop_d;
    logic              done_q, done_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic [BEAT_W-1:0] re_q, re_d;
    logic [BEAT_W-1:0] im_q, im_d;

    logic                 xfer;
    logic [PHASES-1:0]    bank_we;
    logic [PHASES-1:0]    lane_keep;
    logic [ROW_W-1:0]     wr_row;
    logic [DATAWIDTH-1:0] bank_re [PHASES];
    logic [DATAWIDTH-1:0] bank_im [PHASES];

    function automatic logic [ROW_W-1:0] last_row_of(input logic [LEN_W-1:0] len);
        logic [LEN_W:0] rows;
        rows = ({1'b0, len} + (LEN_W+1)'(PHASES - 1)) >> LANE_SH;
        return ROW_W'(rows - (LEN_W+1)'(1));
    endfunction

    assign xfer   = valid_q & ready_i;
    assign wr_row = ROW_W'(wr_addr_i >> LANE_SH);

    // Writes are only honoured while idle so a playing frame never tears.
    always_comb begin
        bank_we = '0;
        for (int k = 0; k < PHASES; k++) begin
            bank_we[k] = wr_en_i && (state_q == StIdle) &&
                         ((wr_addr_i & ADDR_W'(PHASES - 1)) == ADDR_W'(k));
        end
    end

    for (genvar k = 0; k < PHASES; k++) begin : g_bank
        iq_bank_mem #(
            .DATAWIDTH (DATAWIDTH),
            .ROWS      (ROWS),
            .ROW_W     (ROW_W)
        ) u_bank (
            .clk_i    (clk_i),
            .wr_en_i  (bank_we[k]),
            .wr_row_i (wr_row),
            .wr_re_i  (wr_re_i),
            .wr_im_i  (wr_im_i),
            .rd_row_i (row_d),
            .rd_re_o  (bank_re[k]),
            .rd_im_o  (bank_im[k])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            row_q      <= '0;
            last_row_q <= '0;
            gap_cnt_q  <= '0;
            len_q      <= '0;
            gap_q      <= '0;
            loop_q     <= 1'b0;
            stop_q     <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            re_q       <= '0;
            im_q       <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            last_row_q <= last_row_d;
            gap_cnt_q  <= gap_cnt_d;
            len_q      <= len_d;
            gap_q      <= gap_d;
            loop_q     <= loop_d;
            stop_q     <= stop_d;
            done_q     <= done_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            re_q       <= re_d;
            im_q       <= im_d;
        end
    end

    // Next state advances only on a transfer, so a stalled beat is never skipped.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        last_row_d = last_row_q;
        gap_cnt_d  = gap_cnt_q;
        len_d      = len_q;
        gap_d      = gap_q;
        loop_d     = loop_q;
        stop_d     = stop_q;
        done_d     = 1'b0;
        load_sel   = LdHold;
        unique case (state_q)
            StIdle: begin
                stop_d = 1'b0;
                if (start_i && (len_i != '0)) begin
                    state_d    = StPlay;
                    row_d      = '0;
                    len_d      = len_i;
                    gap_d      = gap_i;
                    loop_d     = loop_i;
                    last_row_d = last_row_of(len_i);
                    stop_d     = stop_i;
                    load_sel   = LdRow;
                end
            end
            StPlay: begin
                stop_d = stop_q | stop_i;
                if (xfer) begin
                    if (stop_q) begin
                        state_d  = StIdle;
                        row_d    = '0;
                        stop_d   = 1'b0;
                        done_d   = 1'b1;
                        load_sel = LdClear;
                    end else if (row_q != last_row_q) begin
                        row_d    = row_q + ROW_W'(1);
                        load_sel = LdRow;
                    end else if (gap_q != '0) begin
                        state_d   = StGap;
                        row_d     = '0;
                        gap_cnt_d = gap_q - GAP_W'(1);
                        load_sel  = LdZero;
                    end else if (loop_q) begin
                        row_d    = '0;
                        load_sel = LdRow;
                    end else begin
                        state_d  = StIdle;
                        row_d    = '0;
                        done_d   = 1'b1;
                        load_sel = LdClear;
                    end
                end
            end
            StGap: begin
                stop_d = stop_q | stop_i;
                if (xfer) begin
                    if (stop_q) begin
                        state_d  = StIdle;
                        stop_d   = 1'b0;
                        done_d   = 1'b1;
                        load_sel = LdClear;
                    end else if (gap_cnt_q != '0) begin
                        gap_cnt_d = gap_cnt_q - GAP_W'(1);
                        load_sel  = LdZero;
                    end else if (loop_q) begin
                        state_d  = StPlay;
                        row_d    = '0;
                        load_sel = LdRow;
                    end else begin
                        state_d  = StIdle;
                        done_d   = 1'b1;
                        load_sel = LdClear;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Lanes past the frame length read as zero.
    always_comb begin
        lane_keep = '0;
        for (int k = 0; k < PHASES; k++) begin
            lane_keep[k] = ((((LEN_W+1)'(row_d)) << LANE_SH) + (LEN_W+1)'(k)) < {1'b0, len_d};
        end
    end

    always_comb begin
        valid_d = valid_q;
        last_d  = last_q;
        re_d    = re_q;
        im_d    = im_q;
        unique case (load_sel)
            LdRow: begin
                valid_d = 1'b1;
                last_d  = (row_d == last_row_d);
                for (int k = 0; k < PHASES; k++) begin
                    re_d[k*DATAWIDTH +: DATAWIDTH] = lane_keep[k] ? bank_re[k] : '0;
                    im_d[k*DATAWIDTH +: DATAWIDTH] = lane_keep[k] ? bank_im[k] : '0;
                end
            end
            LdZero: begin
                valid_d = 1'b1;
                last_d  = 1'b0;
                re_d    = '0;
                im_d    = '0;
            end
            LdClear: begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                re_d    = '0;
                im_d    = '0;
            end
            default: begin
                valid_d = valid_q;
            end
        endcase
    end

    assign re_o    = re_q;
    assign im_o    = im_q;
    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign busy_o  = (state_q != StIdle);
    assign done_o  = done_q;

endmodule

// File: tb/tb_iq_beat_player.sv
// Directed bench for iq_beat_player at PHASES=4, DEPTH=16: vector table plus corner sequences.
module tb_iq_beat_player;

    localparam int unsigned DW  = 16;
    localparam int unsigned PH  = 4;
    localparam int unsigned DEP = 16;
    localparam int unsigned GW  = 8;
    localparam int unsigned AW  = 4;
    localparam int unsigned LW  = 5;

    localparam logic [63:0] R0 = 64'h0003_0002_0001_0000;
    localparam logic [63:0] R1 = 64'h0007_0006_0005_0004;
    localparam logic [63:0] R2 = 64'h000B_000A_0009_0008;
    localparam logic [63:0] R3 = 64'h000F_000E_000D_000C;
    localparam logic [63:0] I0 = 64'hFFFD_FFFE_FFFF_0000;
    localparam logic [63:0] I1 = 64'hFFF9_FFFA_FFFB_FFFC;
    localparam logic [63:0] I2 = 64'hFFF5_FFF6_FFF7_FFF8;
    localparam logic [63:0] I3 = 64'hFFF1_FFF2_FFF3_FFF4;
    localparam logic [63:0] Z  = 64'h0;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0;
    logic [AW-1:0]     wr_addr = '0;
    logic [DW-1:0]     wr_re = '0;
    logic [DW-1:0]     wr_im = '0;
    logic [LW-1:0]     len = '0;
    logic [GW-1:0]     gap = '0;
    logic              loop_en = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              ready = 1'b1;
    logic [DW*PH-1:0]  re_o;
    logic [DW*PH-1:0]  im_o;
    logic              valid_o;
    logic              last_o;
    logic              busy_o;
    logic              done_o;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        start;
        logic [4:0]  len;
        logic [63:0] re;
        logic [63:0] im;
        logic [3:0]  flags;  // {valid, last, busy, done}
    } vec_t;

    vec_t        vecs [14];
    logic [63:0] exp_re [7];
    logic        exp_last [7];

    iq_beat_player #(
        .DATAWIDTH (DW),
        .PHASES    (PH),
        .DEPTH     (DEP),
        .GAP_W     (GW)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_re_i   (wr_re),
        .wr_im_i   (wr_im),
        .len_i     (len),
        .gap_i     (gap),
        .loop_i    (loop_en),
        .start_i   (start),
        .stop_i    (stop),
        .re_o      (re_o),
        .im_o      (im_o),
        .valid_o   (valid_o),
        .ready_i   (ready),
        .last_o    (last_o),
        .busy_o    (busy_o),
        .done_o    (done_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [131:0] act, input logic [131:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        vecs[0]  = '{1'b1, 5'd16, R0, I0, 4'b1010};
        vecs[1]  = '{1'b0, 5'd16, R1, I1, 4'b1010};
        vecs[2]  = '{1'b0, 5'd16, R2, I2, 4'b1010};
        vecs[3]  = '{1'b0, 5'd16, R3, I3, 4'b1110};
        vecs[4]  = '{1'b0, 5'd16, Z,  Z,  4'b0001};
        vecs[5]  = '{1'b0, 5'd16, Z,  Z,  4'b0000};
        vecs[6]  = '{1'b1, 5'd10, R0, I0, 4'b1010};
        vecs[7]  = '{1'b0, 5'd10, R1, I1, 4'b1010};
        vecs[8]  = '{1'b0, 5'd10, 64'h0000_0000_0009_0008, 64'h0000_0000_FFF7_FFF8, 4'b1110};
        vecs[9]  = '{1'b0, 5'd10, Z,  Z,  4'b0001};
        vecs[10] = '{1'b1, 5'd0,  Z,  Z,  4'b0000};
        vecs[11] = '{1'b1, 5'd6,  R0, I0, 4'b1010};
        vecs[12] = '{1'b0, 5'd6,  64'h0000_0000_0005_0004, 64'h0000_0000_FFFB_FFFC, 4'b1110};
        vecs[13] = '{1'b0, 5'd6,  Z,  Z,  4'b0001};

        exp_re[0] = R0; exp_re[1] = R1; exp_re[2] = R2; exp_re[3] = R3;
        exp_re[4] = Z;  exp_re[5] = Z;  exp_re[6] = R0;
        exp_last[0] = 1'b0; exp_last[1] = 1'b0; exp_last[2] = 1'b0; exp_last[3] = 1'b1;
        exp_last[4] = 1'b0; exp_last[5] = 1'b0; exp_last[6] = 1'b0;

        #12;
        check("reset_state", 132'({re_o, im_o, valid_o, last_o, busy_o, done_o}), 132'(0));
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 16; i++) begin
            wr_en   = 1'b1;
            wr_addr = AW'(i);
            wr_re   = DW'(i);
            wr_im   = DW'(-i);
            step();
        end
        wr_en = 1'b0;

        // One-shot frames, partial frame, len=0 ignored, ready held high
        for (int i = 0; i < 14; i++) begin
            start = vecs[i].start;
            len   = vecs[i].len;
            step();
            start = 1'b0;
            check($sformatf("vec%0d", i),
                  132'({re_o, im_o, valid_o, last_o, busy_o, done_o}),
                  {vecs[i].re, vecs[i].im, vecs[i].flags});
        end

        // start and stop together: exactly one beat
        len = 5'd16; loop_en = 1'b1; start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        check("ss_beat", 132'({re_o, valid_o}), 132'({R0, 1'b1}));
        step();
        check("ss_end", 132'({valid_o, busy_o, done_o}), 132'(3'b001));
        step();
        check("ss_quiet", 132'({valid_o, busy_o, done_o}), 132'(3'b000));

        // Loop with gap of 2, no bubble on wrap
        gap = 8'd2; loop_en = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            check($sformatf("gap_beat%0d", i), 132'({re_o, valid_o, last_o}),
                  132'({exp_re[i], 1'b1, exp_last[i]}));
            step();
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("gap_stop_beat", 132'({re_o, valid_o}), 132'({R2, 1'b1}));
        step();
        check("gap_stop_end", 132'({valid_o, busy_o, done_o}), 132'(3'b001));
        step();

        // Backpressure on beat 1, then stop while beat 2 is stalled
        gap = 8'd0; loop_en = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        step();
        ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            step();
            check($sformatf("bp_hold%0d", j), 132'({re_o, im_o, valid_o, last_o}),
                  132'({R1, I1, 1'b1, 1'b0}));
        end
        ready = 1'b1;
        step();
        check("bp_next", 132'({re_o, im_o, valid_o}), 132'({R2, I2, 1'b1}));
        ready = 1'b0; stop = 1'b1;
        step();
        stop = 1'b0;
        check("stall_stop_hold0", 132'({re_o, valid_o}), 132'({R2, 1'b1}));
        step();
        check("stall_stop_hold1", 132'({re_o, valid_o}), 132'({R2, 1'b1}));
        ready = 1'b1;
        step();
        check("stall_stop_end", 132'({re_o, valid_o, busy_o, done_o}), 132'({Z, 3'b001}));
        step();
        check("stall_no_beat3", 132'({valid_o, busy_o, done_o}), 132'(3'b000));

        // Write while playing is dropped
        loop_en = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        wr_en = 1'b1; wr_addr = 4'd1; wr_re = 16'h0055; wr_im = 16'h0000;
        step();
        wr_en = 1'b0;
        for (int j = 0; j < 4; j++) step();
        start = 1'b1;
        step();
        start = 1'b0;
        check("replay_row0", 132'({re_o, im_o}), 132'({R0, I0}));
        for (int j = 0; j < 5; j++) step();

        // Asynchronous reset mid-play
        loop_en = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        check("pre_rst_valid", 132'(valid_o), 132'(1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", 132'({re_o, im_o, valid_o, last_o, busy_o, done_o}), 132'(0));
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_idle", 132'({valid_o, busy_o, done_o}), 132'(3'b000));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
